// File: rtl/rv_pkg.sv
// Shared RISC-V front-end types and constants.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer between the instruction memory and IF/ID.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok = pop && (count_q != '0);
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  // Next-state: flush wins over push/pop; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop_ok && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues memory requests within a
// credit window of DEPTH, buffers responses and drops stale ones after redirects.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] occupancy;
  logic [31:0]      redirect_tgt;
  logic             gnt_fire;
  logic             push;
  logic             pop;
  fetch_entry_t     push_data;
  fetch_entry_t     head;

  // Credits in use: in-flight (kept or dropped) plus buffered instructions.
  assign occupancy    = SUM_W'(out_cnt_q) + SUM_W'(disc_cnt_q) + SUM_W'(fifo_count);
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req  = !rst && !redirect_valid && (occupancy < SUM_W'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req && imem_gnt;

  // Responses are in order, so the PC of the next kept response is implied.
  assign push      = imem_rvalid && !redirect_valid && (disc_cnt_q == '0);
  assign push_data = '{pc: resp_pc_q, instr: imem_rdata};
  assign pop       = if_valid && !stall && !redirect_valid;

  assign if_valid = (fifo_count != '0);
  assign if_pc    = if_valid ? head.pc : 32'h0;
  assign if_instr = if_valid ? head.instr : NOP_INSTR;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

  // Next-state for PC tracking and outstanding/discard accounting.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_cnt_d  = out_cnt_q;
    disc_cnt_d = disc_cnt_q;
    if (redirect_valid) begin
      // Everything still in flight becomes stale; a response arriving now is
      // one of them and is dropped on the spot.
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      out_cnt_d  = '0;
      disc_cnt_d = disc_cnt_q + out_cnt_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid && (disc_cnt_q != '0)) begin
        disc_cnt_d = disc_cnt_q - CNT_W'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
      out_cnt_d = out_cnt_q + CNT_W'(gnt_fire) - CNT_W'(push);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    occupancy <= SUM_W'(DEPTH));

  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> ((SUM_W'(out_cnt_q) + SUM_W'(disc_cnt_q)) != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then random traffic against a
// queue-based reference model, then a mid-stream reset.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] SALT     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          drop;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          gnt;
    bit          rv_en;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  bit          rv_en = 1'b1;
  pend_t       pend[$];
  ent_t        vis[$];
  logic [31:0] m_pc = RESET_PC;
  vec_t        tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input bit st, input bit rd, input logic [31:0] rpc, input bit g,
                              input bit rv, input bit rq, input logic [31:0] ad,
                              input bit v, input logic [31:0] pc);
    vec_t r;
    r.stall = st; r.redir = rd; r.rpc = rpc; r.gnt = g; r.rv_en = rv;
    r.req = rq; r.addr = ad; r.valid = v; r.pc = pc;
    return r;
  endfunction

  // Memory side: return the oldest pending request once its latency has elapsed.
  task automatic settle();
    if (rv_en && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr ^ SALT;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
  endtask

  // Compare against the reference model, then advance model and clock.
  task automatic check_and_advance();
    bit          ereq, ev;
    logic [31:0] epc, einst;
    pend_t       r;
    ent_t        e;
    ereq  = !redirect_valid && ((pend.size() + vis.size()) < int'(DEPTH));
    ev    = (vis.size() != 0);
    epc   = ev ? vis[0].pc : 32'h0;
    einst = ev ? vis[0].instr : NOP;
    chk("m_req",   32'(imem_req), 32'(ereq));
    chk("m_addr",  imem_addr,     m_pc);
    chk("m_valid", 32'(if_valid), 32'(ev));
    chk("m_pc",    if_pc,         epc);
    chk("m_instr", if_instr,      einst);

    if (ev && !stall && !redirect_valid) void'(vis.pop_front());
    if (imem_rvalid && pend.size() != 0) begin
      r = pend.pop_front();
      if (!r.drop && !redirect_valid) begin
        e.pc = r.addr; e.instr = imem_rdata;
        vis.push_back(e);
      end
    end
    if (redirect_valid) begin
      vis.delete();
      for (int i = 0; i < pend.size(); i++) begin
        r = pend[i]; r.drop = 1'b1; pend[i] = r;
      end
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (imem_req && imem_gnt) begin
      m_pc = m_pc + 32'd4;
    end
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr; r.due = cyc + lat; r.drop = redirect_valid;
      pend.push_back(r);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    // DEPTH=4, gnt every cycle, 1-cycle latency: full rate, stall, redirect.
    tbl[0]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h000, 0, 32'h000);
    tbl[1]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h004, 0, 32'h000);
    tbl[2]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h008, 1, 32'h000);
    tbl[3]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h00C, 1, 32'h004);
    tbl[4]  = mk(1, 0, 32'h0,   1, 1, 1, 32'h010, 1, 32'h008);
    tbl[5]  = mk(1, 0, 32'h0,   1, 1, 1, 32'h014, 1, 32'h008);
    tbl[6]  = mk(1, 0, 32'h0,   1, 1, 0, 32'h018, 1, 32'h008);
    tbl[7]  = mk(1, 0, 32'h0,   1, 1, 0, 32'h018, 1, 32'h008);
    tbl[8]  = mk(1, 0, 32'h0,   1, 1, 0, 32'h018, 1, 32'h008);
    tbl[9]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h018, 1, 32'h008);
    tbl[10] = mk(0, 0, 32'h0,   1, 1, 1, 32'h018, 1, 32'h00C);
    tbl[11] = mk(0, 0, 32'h0,   1, 1, 1, 32'h01C, 1, 32'h010);
    tbl[12] = mk(0, 0, 32'h0,   1, 1, 1, 32'h020, 1, 32'h014);
    tbl[13] = mk(0, 0, 32'h0,   1, 1, 1, 32'h024, 1, 32'h018);
    tbl[14] = mk(0, 0, 32'h0,   1, 0, 1, 32'h028, 1, 32'h01C);
    tbl[15] = mk(0, 1, 32'h103, 1, 1, 0, 32'h02C, 1, 32'h020);
    tbl[16] = mk(0, 0, 32'h0,   1, 1, 1, 32'h100, 0, 32'h000);
    tbl[17] = mk(0, 0, 32'h0,   1, 1, 1, 32'h104, 0, 32'h000);
    tbl[18] = mk(0, 0, 32'h0,   1, 1, 1, 32'h108, 1, 32'h100);
    tbl[19] = mk(0, 0, 32'h0,   1, 1, 1, 32'h10C, 1, 32'h104);

    // Reset values while rst is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_pc",    if_pc,         32'h0);
    chk("rst_instr", if_instr,      NOP);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    cyc = 0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      stall          = tbl[i].stall;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      imem_gnt       = tbl[i].gnt;
      rv_en          = tbl[i].rv_en;
      settle();
      chk($sformatf("row%0d_req", i),   32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i),  imem_addr,     tbl[i].addr);
      chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(tbl[i].valid));
      chk($sformatf("row%0d_pc", i),    if_pc,         tbl[i].pc);
      chk($sformatf("row%0d_instr", i), if_instr,      tbl[i].valid ? (tbl[i].pc ^ SALT) : NOP);
      check_and_advance();
    end

    // Random traffic: 3-cycle latency, random gnt/stall/redirect/response delay.
    lat = 3;
    for (int n = 0; n < 1500; n++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      imem_gnt       = $urandom_range(0, 1) == 1;
      rv_en          = ($urandom_range(0, 3) != 0);
      settle();
      check_and_advance();
    end

    // Fill the buffer under stall, then reset mid-stream.
    stall = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b1; rv_en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      settle();
      check_and_advance();
    end
    #1;
    chk("pre_rst_valid", 32'(if_valid), 32'h1);
    rst = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_valid), 32'h0);
    chk("mid_rst_req",   32'(imem_req), 32'h0);
    chk("mid_rst_instr", if_instr,      NOP);
    pend.delete();
    vis.delete();
    m_pc = RESET_PC;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    settle();
    chk("post_rst_req",  32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr,     RESET_PC);
    check_and_advance();
    for (int n = 0; n < 60; n++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      imem_gnt       = $urandom_range(0, 1) == 1;
      rv_en          = 1'b1;
      settle();
      check_and_advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
